jk_register_bank: RTL and testbench

Parametrised multi-bit register built from JK-cell semantics, extending the single JK flip-flop used in the irrigation controller's timing and sequencing logic. Each bit can act as an independent JK cell, or the whole word can be parallel-loaded, run as a wrapping up/down counter, or shifted serially. It replaces ad-hoc chains of discrete flip-flops in the watering-cycle timers and valve-sequencing logic.

---
 rtl/jk_register_bank.sv | 44 ++++
 tb/tb_jk_register_bank.sv | 121 ++++++++++++
 2 files changed

// File: rtl/jk_register_bank.sv
// jk_register_bank: per-bit JK / load / up-down count / serial shift register word; `JKR_SHIFT_MODE_EN enables mode 11 shifting
module jk_register_bank #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             preset,
  input  logic             sclr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             ser_out
);
  logic [WIDTH-1:0] nxt, cnt, sh;
  assign cnt = dir ? q + WIDTH'(1) : q - WIDTH'(1);
`ifdef JKR_SHIFT_MODE_EN
  assign sh = (q << 1) | WIDTH'(ser_in);
  assign ser_out = q[WIDTH-1];
`else
  logic unused_ser_in;
  assign unused_ser_in = ser_in;
  assign sh = q;
  assign ser_out = 1'b0;
`endif
  // next word for the selected mode; JK uses the characteristic equation j&~q | ~k&q
  always_comb
    nxt = mode == 2'b00 ? (j & ~q) | (~k & q) :
          mode == 2'b01 ? d :
          mode == 2'b10 ? cnt : sh;
  // async preset dominates, then sync clear, then enable
  always_ff @(posedge clk or posedge preset)
    if (preset) q <= PRESET_VAL;
    else if (sclr) q <= '0;
    else if (en) q <= nxt;
  assign q_bar = ~q;
  assign tc = en & ~sclr & (mode == 2'b10) & (dir ? &q : ~|q);
endmodule

// File: tb/tb_jk_register_bank.sv
// tb_jk_register_bank: directed and random checks of jk_register_bank against an arithmetic reference model
module tb_jk_register_bank;
  logic clk = 0, preset = 0, sclr = 0, en = 0, dir = 0, ser_in = 0;
  logic [1:0] mode = 0;
  logic [3:0] j = 0, k = 0, d = 0, q, q_bar;
  logic tc, ser_out;
  int m, total = 0, passed = 0;

  jk_register_bank #(.WIDTH(4), .PRESET_VAL(4'hA)) dut (
    .clk(clk), .preset(preset), .sclr(sclr), .en(en), .mode(mode), .j(j), .k(k),
    .d(d), .dir(dir), .ser_in(ser_in), .q(q), .q_bar(q_bar), .tc(tc), .ser_out(ser_out));

  always #5 clk = ~clk;

`ifdef JKR_SHIFT_MODE_EN
  localparam bit SHIFT_ON = 1;
`else
  localparam bit SHIFT_ON = 0;
`endif

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_next(int cur);
    int r;
    if (sclr) return 0;
    if (!en) return cur;
    case (mode)
      2'd0: begin
        r = 0;
        for (int b = 0; b < 4; b++) begin
          int bit_q = (cur >> b) & 1;
          int jk = j[b] * 2 + k[b];
          int nb = jk == 0 ? bit_q : jk == 1 ? 0 : jk == 2 ? 1 : 1 - bit_q;
          r += nb << b;
        end
        return r;
      end
      2'd1: return d;
      2'd2: return dir ? (cur + 1) % 16 : (cur + 15) % 16;
      default: return SHIFT_ON ? (cur * 2 + ser_in) % 16 : cur;
    endcase
  endfunction

  function automatic int model_tc(int cur);
    return (en && !sclr && mode == 2 && (dir ? cur == 15 : cur == 0)) ? 1 : 0;
  endfunction

  task automatic check_state(string tag);
    chk({tag, ".q"}, q, m);
    chk({tag, ".q_bar"}, q_bar, 15 - m);
    chk({tag, ".ser_out"}, ser_out, SHIFT_ON ? (m >> 3) & 1 : 0);
  endtask

  task automatic step(string tag);
    int nx;
    #1;
    chk({tag, ".tc"}, tc, model_tc(m));
    nx = model_next(m);
    @(posedge clk);
    #1;
    m = nx;
    check_state(tag);
  endtask

  task automatic set(bit s, bit e, logic [1:0] md, logic [3:0] dd);
    sclr = s; en = e; mode = md; d = dd;
  endtask

  initial begin
    #3 preset = 1;
    #1 m = 'hA;
    check_state("preset_async");
    chk("preset_tc", tc, 0);
    @(posedge clk);
    #1 check_state("preset_held");
    #2 preset = 0;
    @(posedge clk);
    #1 check_state("after_release");
    set(1, 0, 0, 0); step("sclr");
    set(0, 1, 1, 4'hA); step("load_a");
    set(0, 1, 0, 0); j = 4'b1100; k = 4'b1010; step("jk");
    set(0, 1, 1, 4'hE); step("load_e");
    set(0, 1, 2, 0); dir = 1;
    step("up_f"); step("up_0"); step("up_1");
    dir = 0; step("dn_0"); step("dn_f");
    set(0, 1, 1, 4'hA); step("load_a2");
    set(0, 1, 3, 0);
    ser_in = 1; step("sh1");
    ser_in = 1; step("sh2");
    ser_in = 0; step("sh3");
    set(0, 0, 1, 4'h3); step("en_hold");
    set(1, 1, 2, 0); dir = 1; step("sclr_cnt");
    set(0, 1, 1, 4'h7); step("load_7");
    set(0, 1, 2, 0); dir = 1;
    #2 preset = 1;
    #1 m = 'hA;
    check_state("preset_mid");
    #1 preset = 0;
    step("resume_b"); step("resume_c");
    for (int i = 0; i < 300; i++) begin
      sclr = ($urandom_range(0, 15) == 0);
      en = ($urandom_range(0, 5) != 0);
      mode = 2'($urandom_range(0, 3));
      j = 4'($urandom); k = 4'($urandom); d = 4'($urandom);
      dir = 1'($urandom); ser_in = 1'($urandom);
      if ($urandom_range(0, 30) == 0) begin
        #2 preset = 1;
        #1 m = 'hA;
        check_state("rnd_preset");
        #1 preset = 0;
      end
      step("rnd");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
